// File: rtl/axi_bridge_mp.sv
// Multi-port SRAM-like to AXI3 bridge: NPORT masters share one AXI master port.
// Reads are pipelined per port (port index = AXI ID); one write is in flight globally.
module axi_bridge_mp #(
    parameter int NPORT    = 2,
    parameter int RD_OUTST = 2,
    parameter int ARB_RR   = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NPORT-1:0]    p_req,
    input  logic [NPORT-1:0]    p_wr,
    input  logic [2*NPORT-1:0]  p_size,
    input  logic [4*NPORT-1:0]  p_wstrb,
    input  logic [32*NPORT-1:0] p_addr,
    input  logic [32*NPORT-1:0] p_wdata,
    output logic [NPORT-1:0]    p_addr_ok,
    output logic [NPORT-1:0]    p_data_ok,
    output logic [32*NPORT-1:0] p_rdata,
    output logic [3:0]          arid,
    output logic [31:0]         araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [1:0]          arlock,
    output logic [3:0]          arcache,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,
    input  logic [3:0]          rid,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    output logic [3:0]          awid,
    output logic [31:0]         awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [1:0]          awlock,
    output logic [3:0]          awcache,
    output logic [2:0]          awprot,
    output logic                awvalid,
    input  logic                awready,
    output logic [3:0]          wid,
    output logic [31:0]         wdata,
    output logic [3:0]          wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [3:0]          bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    typedef enum logic [1:0] {W_IDLE, W_SEND, W_BWAIT} wstate_t;

    wstate_t     wstate;
    logic [3:0]  req4, wr4;
    logic [1:0]  size4  [4];
    logic [3:0]  strb4  [4];
    logic [31:0] addr4  [4];
    logic [31:0] wdata4 [4];
    logic [2:0]  rd_cnt [4];
    logic [1:0]  rd_ptr, wr_ptr, rd_idx, wr_idx, wr_owner;
    logic [3:0]  rd_elig, wr_elig, cnt_inc, cnt_dec, addr_ok4, data_ok4;
    logic        rd_gnt, wr_gnt, rd_ret, wr_done, ar_free, wr_pend;
    logic        unused_ok;

    // Unused port slots are padded with zeros so every lookup is a fixed 4-entry table.
    for (genvar i = 0; i < 4; i++) begin : g_fld
        if (i < NPORT) begin : g_on
            assign req4[i]   = p_req[i];
            assign wr4[i]    = p_wr[i];
            assign size4[i]  = p_size[2*i +: 2];
            assign strb4[i]  = p_wstrb[4*i +: 4];
            assign addr4[i]  = p_addr[32*i +: 32];
            assign wdata4[i] = p_wdata[32*i +: 32];
        end else begin : g_off
            assign req4[i]   = 1'b0;
            assign wr4[i]    = 1'b0;
            assign size4[i]  = '0;
            assign strb4[i]  = '0;
            assign addr4[i]  = '0;
            assign wdata4[i] = '0;
        end
    end

    // Returns {found, index}; round-robin searches upward from ptr, fixed priority from 0.
    function automatic logic [2:0] pick(input logic [3:0] elig, input logic [1:0] ptr);
        int idx;
        logic found;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NPORT; k++) begin
            idx = (ARB_RR != 0) ? (int'(ptr) + k) % NPORT : k;
            if (!found && elig[idx[1:0]]) begin
                found = 1'b1;
                pick  = {1'b1, idx[1:0]};
            end
        end
    endfunction

    function automatic logic [1:0] ptr_next(input logic [1:0] idx);
        int n;
        n = (int'(idx) + 1) % NPORT;
        return n[1:0];
    endfunction

    always_comb begin
        ar_free  = !arvalid || arready;
        wr_pend  = (wstate != W_IDLE);
        rd_elig  = '0;
        wr_elig  = '0;
        for (int i = 0; i < 4; i++) begin
            rd_elig[i] = req4[i] && !wr4[i] && ar_free && (rd_cnt[i] < 3'(RD_OUTST))
                         && !(wr_pend && addr4[i][31:2] == awaddr[31:2]);
            wr_elig[i] = req4[i] && wr4[i] && !wr_pend;
        end
        {rd_gnt, rd_idx} = pick(rd_elig, rd_ptr);
        {wr_gnt, wr_idx} = pick(wr_elig, wr_ptr);
        rd_ret   = rvalid && (rid < 4'(NPORT));
        // A read return to the write owner wins; B waits a cycle.
        bready   = (wstate == W_BWAIT) && !(rd_ret && rid[1:0] == wr_owner);
        wr_done  = bvalid && bready;
        addr_ok4 = '0;
        data_ok4 = '0;
        cnt_inc  = '0;
        cnt_dec  = '0;
        if (rd_gnt) begin
            addr_ok4[rd_idx] = 1'b1;
            cnt_inc[rd_idx]  = 1'b1;
        end
        if (wr_gnt)  addr_ok4[wr_idx] = 1'b1;
        if (rd_ret) begin
            data_ok4[rid[1:0]] = 1'b1;
            cnt_dec[rid[1:0]]  = 1'b1;
        end
        if (wr_done) data_ok4[wr_owner] = 1'b1;
    end

    assign p_addr_ok = addr_ok4[NPORT-1:0] & {NPORT{resetn}};
    assign p_data_ok = data_ok4[NPORT-1:0] & {NPORT{resetn}};
    assign p_rdata   = {NPORT{rdata}};

    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign rready  = 1'b1;
    assign awlen   = 8'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = awid;
    assign wlast   = 1'b1;
    assign unused_ok = ^{rresp, bresp, bid, rlast};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arvalid <= 1'b0;
            araddr  <= '0;
            arid    <= '0;
            arsize  <= '0;
            rd_ptr  <= '0;
            for (int i = 0; i < 4; i++) rd_cnt[i] <= '0;
        end else begin
            if (rd_gnt) begin
                arvalid <= 1'b1;
                araddr  <= addr4[rd_idx];
                arid    <= {2'b00, rd_idx};
                arsize  <= {1'b0, size4[rd_idx]};
                rd_ptr  <= ptr_next(rd_idx);
            end else if (arready) begin
                arvalid <= 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                if (cnt_inc[i] && !cnt_dec[i])
                    rd_cnt[i] <= rd_cnt[i] + 3'd1;
                else if (!cnt_inc[i] && cnt_dec[i] && rd_cnt[i] != 3'd0)
                    rd_cnt[i] <= rd_cnt[i] - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wstate   <= W_IDLE;
            awvalid  <= 1'b0;
            wvalid   <= 1'b0;
            awaddr   <= '0;
            awid     <= '0;
            awsize   <= '0;
            wdata    <= '0;
            wstrb    <= '0;
            wr_owner <= '0;
            wr_ptr   <= '0;
        end else begin
            case (wstate)
                W_IDLE: if (wr_gnt) begin
                    awvalid  <= 1'b1;
                    wvalid   <= 1'b1;
                    awaddr   <= addr4[wr_idx];
                    awid     <= {2'b00, wr_idx};
                    awsize   <= {1'b0, size4[wr_idx]};
                    wdata    <= wdata4[wr_idx];
                    wstrb    <= strb4[wr_idx];
                    wr_owner <= wr_idx;
                    wr_ptr   <= ptr_next(wr_idx);
                    wstate   <= W_SEND;
                end
                W_SEND: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    if ((!awvalid || awready) && (!wvalid || wready)) wstate <= W_BWAIT;
                end
                W_BWAIT: if (wr_done) wstate <= W_IDLE;
                default: wstate <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_bridge_mp.sv
// Directed bench for axi_bridge_mp: a round-robin instance is fully checked, a
// fixed-priority twin on the same inputs is checked for its grant pattern.
module tb_axi_bridge_mp;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  p_req, p_wr;
    logic [3:0]  p_size;
    logic [7:0]  p_wstrb;
    logic [63:0] p_addr, p_wdata;
    logic        arready, rvalid, rlast, awready, wready, bvalid;
    logic [3:0]  rid, bid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;

    logic [1:0]  p_addr_ok, p_data_ok;
    logic [63:0] p_rdata;
    logic [3:0]  arid, arcache, awid, awcache, wid, wstrb;
    logic [31:0] araddr, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock;
    logic        arvalid, rready, awvalid, wlast, wvalid, bready;

    logic [1:0]  f_addr_ok, f_data_ok;
    logic [63:0] f_rdata;
    logic [3:0]  f_arid, f_arcache, f_awid, f_awcache, f_wid, f_wstrb;
    logic [31:0] f_araddr, f_awaddr, f_wdata;
    logic [7:0]  f_arlen, f_awlen;
    logic [2:0]  f_arsize, f_arprot, f_awsize, f_awprot;
    logic [1:0]  f_arburst, f_arlock, f_awburst, f_awlock;
    logic        f_arvalid, f_rready, f_awvalid, f_wlast, f_wvalid, f_bready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi_bridge_mp #(.NPORT(2), .RD_OUTST(2), .ARB_RR(1)) dut (
        .clk(clk), .resetn(resetn), .p_req(p_req), .p_wr(p_wr), .p_size(p_size),
        .p_wstrb(p_wstrb), .p_addr(p_addr), .p_wdata(p_wdata), .p_addr_ok(p_addr_ok),
        .p_data_ok(p_data_ok), .p_rdata(p_rdata), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb),
        .wlast(wlast), .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp),
        .bvalid(bvalid), .bready(bready)
    );

    axi_bridge_mp #(.NPORT(2), .RD_OUTST(2), .ARB_RR(0)) dut_fixed (
        .clk(clk), .resetn(resetn), .p_req(p_req), .p_wr(p_wr), .p_size(p_size),
        .p_wstrb(p_wstrb), .p_addr(p_addr), .p_wdata(p_wdata), .p_addr_ok(f_addr_ok),
        .p_data_ok(f_data_ok), .p_rdata(f_rdata), .arid(f_arid), .araddr(f_araddr),
        .arlen(f_arlen), .arsize(f_arsize), .arburst(f_arburst), .arlock(f_arlock),
        .arcache(f_arcache), .arprot(f_arprot), .arvalid(f_arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(f_rready), .awid(f_awid), .awaddr(f_awaddr), .awlen(f_awlen),
        .awsize(f_awsize), .awburst(f_awburst), .awlock(f_awlock), .awcache(f_awcache),
        .awprot(f_awprot), .awvalid(f_awvalid), .awready(awready), .wid(f_wid),
        .wdata(f_wdata), .wstrb(f_wstrb), .wlast(f_wlast), .wvalid(f_wvalid),
        .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(f_bready)
    );

    typedef struct {
        logic [1:0]  req;
        logic [31:0] a0, a1;
        logic        arready, rvalid;
        logic [3:0]  rid;
        logic [31:0] rdata;
        logic [1:0]  aok, dok;
        logic        arvalid;
        logic [3:0]  arid;
        logic [31:0] araddr;
        logic [1:0]  f_aok;
    } vec_t;

    vec_t vecs [16];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        p_req   = v.req;
        p_wr    = 2'b00;
        p_addr  = {v.a1, v.a0};
        arready = v.arready;
        rvalid  = v.rvalid;
        rid     = v.rid;
        rdata   = v.rdata;
    endtask

    task automatic doReset();
        resetn = 1'b0;
        p_req = '0; p_wr = '0; p_size = 4'b1010; p_wstrb = '0; p_addr = '0; p_wdata = '0;
        arready = 1'b1; rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b1;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        // req, a0, a1, arready, rvalid, rid, rdata, aok, dok, arvalid, arid, araddr, f_aok
        vecs[0]  = '{2'b01, 32'h1000, 32'h0,   1'b1, 1'b0, 4'd0, 32'h0,        2'b01, 2'b00, 1'b0, 4'd0, 32'h0,    2'b01};
        vecs[1]  = '{2'b00, 32'h1000, 32'h0,   1'b1, 1'b0, 4'd0, 32'h0,        2'b00, 2'b00, 1'b1, 4'd0, 32'h1000, 2'b00};
        vecs[2]  = '{2'b00, 32'h1000, 32'h0,   1'b1, 1'b1, 4'd0, 32'hDEADBEEF, 2'b00, 2'b01, 1'b0, 4'd0, 32'h1000, 2'b00};
        vecs[3]  = '{2'b11, 32'h100,  32'h200, 1'b1, 1'b0, 4'd0, 32'h0,        2'b10, 2'b00, 1'b0, 4'd0, 32'h1000, 2'b01};
        vecs[4]  = '{2'b11, 32'h100,  32'h200, 1'b1, 1'b0, 4'd0, 32'h0,        2'b01, 2'b00, 1'b1, 4'd1, 32'h200,  2'b01};
        vecs[5]  = '{2'b11, 32'h100,  32'h200, 1'b1, 1'b0, 4'd0, 32'h0,        2'b10, 2'b00, 1'b1, 4'd0, 32'h100,  2'b10};
        vecs[6]  = '{2'b11, 32'h100,  32'h200, 1'b1, 1'b0, 4'd0, 32'h0,        2'b01, 2'b00, 1'b1, 4'd1, 32'h200,  2'b10};
        vecs[7]  = '{2'b11, 32'h100,  32'h200, 1'b1, 1'b0, 4'd0, 32'h0,        2'b00, 2'b00, 1'b1, 4'd0, 32'h100,  2'b00};
        vecs[8]  = '{2'b00, 32'h100,  32'h200, 1'b1, 1'b1, 4'd1, 32'h11111111, 2'b00, 2'b10, 1'b0, 4'd0, 32'h100,  2'b00};
        vecs[9]  = '{2'b00, 32'h100,  32'h200, 1'b1, 1'b1, 4'd0, 32'h22222222, 2'b00, 2'b01, 1'b0, 4'd0, 32'h100,  2'b00};
        vecs[10] = '{2'b00, 32'h100,  32'h200, 1'b1, 1'b1, 4'd7, 32'h33333333, 2'b00, 2'b00, 1'b0, 4'd0, 32'h100,  2'b00};
        vecs[11] = '{2'b11, 32'h100,  32'h200, 1'b1, 1'b1, 4'd0, 32'h44444444, 2'b10, 2'b01, 1'b0, 4'd0, 32'h100,  2'b01};
        vecs[12] = '{2'b01, 32'h100,  32'h200, 1'b1, 1'b0, 4'd0, 32'h0,        2'b01, 2'b00, 1'b1, 4'd1, 32'h200,  2'b01};
        vecs[13] = '{2'b01, 32'h100,  32'h200, 1'b1, 1'b1, 4'd0, 32'h55555555, 2'b01, 2'b01, 1'b1, 4'd0, 32'h100,  2'b00};
        vecs[14] = '{2'b01, 32'h100,  32'h200, 1'b1, 1'b0, 4'd0, 32'h0,        2'b01, 2'b00, 1'b1, 4'd0, 32'h100,  2'b01};
        vecs[15] = '{2'b01, 32'h100,  32'h200, 1'b1, 1'b0, 4'd0, 32'h0,        2'b00, 2'b00, 1'b1, 4'd0, 32'h100,  2'b00};

        // Reset state, with a request present to show grants are suppressed.
        doReset();
        resetn = 1'b0;
        p_req  = 2'b01;
        @(negedge clk); #1;
        checkOutput("rst aok", 32'(p_addr_ok), 32'h0);
        checkOutput("rst arvalid", 32'(arvalid), 32'h0);
        checkOutput("rst awvalid", 32'(awvalid), 32'h0);
        checkOutput("rst wvalid", 32'(wvalid), 32'h0);
        checkOutput("rst bready", 32'(bready), 32'h0);
        checkOutput("rst arlen/arburst", {arlen, arburst, wlast, rready}, {8'd0, 2'b01, 1'b1, 1'b1});
        @(negedge clk);
        p_req  = 2'b00;
        resetn = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d aok", i), 32'(p_addr_ok), 32'(vecs[i].aok));
            checkOutput($sformatf("v%0d dok", i), 32'(p_data_ok), 32'(vecs[i].dok));
            checkOutput($sformatf("v%0d arvalid", i), 32'(arvalid), 32'(vecs[i].arvalid));
            checkOutput($sformatf("v%0d arid", i), 32'(arid), 32'(vecs[i].arid));
            checkOutput($sformatf("v%0d araddr", i), araddr, vecs[i].araddr);
            checkOutput($sformatf("v%0d fixed aok", i), 32'(f_addr_ok), 32'(vecs[i].f_aok));
            if (vecs[i].dok[0]) checkOutput($sformatf("v%0d rdata0", i), p_rdata[31:0], vecs[i].rdata);
            if (vecs[i].dok[1]) checkOutput($sformatf("v%0d rdata1", i), p_rdata[63:32], vecs[i].rdata);
        end

        // Mid-operation asynchronous reset with arvalid held and port 0 at its limit.
        @(negedge clk);
        p_req = 2'b00; arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h66666666;
        #1 checkOutput("r0 dok", 32'(p_data_ok), 32'h1);
        @(negedge clk);
        rvalid = 1'b0; p_req = 2'b01; p_addr = {32'h0, 32'h4000};
        #1 checkOutput("r1 aok", 32'(p_addr_ok), 32'h1);
        @(negedge clk); #1;
        checkOutput("r2 arvalid", 32'(arvalid), 32'h1);
        checkOutput("r2 araddr", araddr, 32'h4000);
        checkOutput("r2 aok full", 32'(p_addr_ok), 32'h0);
        #2 resetn = 1'b0;
        #1;
        checkOutput("r2 async arvalid", 32'(arvalid), 32'h0);
        checkOutput("r2 rst aok", 32'(p_addr_ok), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        #1 checkOutput("r3 aok after rst", 32'(p_addr_ok), 32'h1);

        // Write path: delayed wready, single bready pulse, second write and aliasing read stall.
        doReset();
        p_req = 2'b10; p_wr = 2'b10; p_addr = {32'h2000, 32'h0};
        p_wdata = {32'h55, 32'h0}; p_wstrb = 8'hF0;
        #1 checkOutput("w0 aok", 32'(p_addr_ok), 32'h2);
        @(negedge clk);
        p_req = 2'b00; p_wr = 2'b00; awready = 1'b1;
        #1;
        checkOutput("w1 awvalid", 32'(awvalid), 32'h1);
        checkOutput("w1 wvalid", 32'(wvalid), 32'h1);
        checkOutput("w1 awaddr", awaddr, 32'h2000);
        checkOutput("w1 awid", 32'(awid), 32'h1);
        checkOutput("w1 wdata", wdata, 32'h55);
        checkOutput("w1 wstrb", 32'(wstrb), 32'hF);
        checkOutput("w1 awsize", 32'(awsize), 32'h2);
        @(negedge clk);
        awready = 1'b0; p_req = 2'b01; p_wr = 2'b01; p_addr = {32'h0, 32'h2004};
        #1;
        checkOutput("w2 awvalid", 32'(awvalid), 32'h0);
        checkOutput("w2 wvalid", 32'(wvalid), 32'h1);
        checkOutput("w2 aok stall", 32'(p_addr_ok), 32'h0);
        checkOutput("w2 bready", 32'(bready), 32'h0);
        @(negedge clk); #1;
        checkOutput("w3 wvalid", 32'(wvalid), 32'h1);
        checkOutput("w3 aok stall", 32'(p_addr_ok), 32'h0);
        @(negedge clk);
        wready = 1'b1;
        #1 checkOutput("w4 wvalid", 32'(wvalid), 32'h1);
        @(negedge clk);
        wready = 1'b0;
        #1;
        checkOutput("w5 wvalid", 32'(wvalid), 32'h0);
        checkOutput("w5 bready", 32'(bready), 32'h1);
        checkOutput("w5 aok stall", 32'(p_addr_ok), 32'h0);
        checkOutput("w5 dok", 32'(p_data_ok), 32'h0);
        @(negedge clk);
        bvalid = 1'b1; bresp = 2'b10; bid = 4'd9;
        #1;
        checkOutput("w6 dok", 32'(p_data_ok), 32'h2);
        checkOutput("w6 aok stall", 32'(p_addr_ok), 32'h0);
        @(negedge clk);
        bvalid = 1'b0;
        #1;
        checkOutput("w7 bready", 32'(bready), 32'h0);
        checkOutput("w7 aok 2nd write", 32'(p_addr_ok), 32'h1);
        @(negedge clk);
        p_wr = 2'b00; p_addr = {32'h0, 32'h2006};
        #1;
        checkOutput("w8 aok alias", 32'(p_addr_ok), 32'h0);
        checkOutput("w8 awaddr", awaddr, 32'h2004);
        @(negedge clk);
        p_addr = {32'h0, 32'h3000};
        #1 checkOutput("w9 aok 0x3000", 32'(p_addr_ok), 32'h1);
        @(negedge clk);
        p_req = 2'b00; awready = 1'b1; wready = 1'b1;
        #1;
        checkOutput("w10 arvalid", 32'(arvalid), 32'h1);
        checkOutput("w10 araddr", araddr, 32'h3000);
        @(negedge clk);
        awready = 1'b0; wready = 1'b0; p_req = 2'b01; p_addr = {32'h0, 32'h2006};
        #1;
        checkOutput("w11 aok alias", 32'(p_addr_ok), 32'h0);
        checkOutput("w11 bready", 32'(bready), 32'h1);
        @(negedge clk);
        bvalid = 1'b1;
        #1;
        checkOutput("w12 dok", 32'(p_data_ok), 32'h1);
        checkOutput("w12 aok alias", 32'(p_addr_ok), 32'h0);
        @(negedge clk);
        bvalid = 1'b0;
        #1 checkOutput("w13 aok alias clear", 32'(p_addr_ok), 32'h1);
        @(negedge clk);
        p_req = 2'b00;
        #1 checkOutput("w14 araddr", araddr, 32'h2006);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
